// File: rtl/seq_detector_param_if.sv
// Bundled control/data/status signals of seq_detector_param.
// master: the serial bit source / controller side; slave: the detector.
interface seq_detector_param_if #(
  parameter int PATTERN_W   = 8,
  parameter int LEN_W       = 4,
  parameter int MATCH_CNT_W = 8
);
  logic                   en;
  logic                   clear;
  logic                   w_valid;
  logic                   w;
  logic [PATTERN_W-1:0]   pattern;
  logic [LEN_W-1:0]       pat_len;
  logic                   overlap;
  logic                   z;
  logic                   busy;
  logic                   cfg_err;
  logic [MATCH_CNT_W-1:0] match_cnt;

  modport master (
    output en, clear, w_valid, w, pattern, pat_len, overlap,
    input  z, busy, cfg_err, match_cnt
  );

  modport slave (
    input  en, clear, w_valid, w, pattern, pat_len, overlap,
    output z, busy, cfg_err, match_cnt
  );
endinterface

// File: rtl/seq_detector_param.sv
// Parametrised serial sequence detector with a runtime-programmable pattern
// of 1..PATTERN_W bits and overlap / restart-after-match modes. The match
// pulse z is registered and appears the cycle after the completing bit.
// Optional saturating match counter: define SEQDET_MATCH_CNT_EN to build it,
// otherwise match_cnt is tied to zero.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  ST_IDLE   | stopped; waiting for en to latch config and start
//  ST_FILL   | running, fewer than pat_len bits collected since start/match
//  ST_DETECT | running, history full; every accepted bit is a match check
module seq_detector_param #(
  parameter int PATTERN_W   = 8,
  parameter int LEN_W       = 4,
  parameter int MATCH_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  seq_detector_param_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_DETECT = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [PATTERN_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]     fill_q, fill_d;
  logic [PATTERN_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic                 ovl_q, ovl_d;
  logic                 z_q, z_d;
  logic                 cfg_err_q, cfg_err_d;

  logic                 running_w;
  logic                 accept_w;
  logic                 len_legal_w;
  logic [PATTERN_W-1:0] hist_shift_w;
  logic [LEN_W-1:0]     fill_inc_w;
  logic [PATTERN_W-1:0] len_mask_w;
  logic                 match_w;

  assign running_w   = (state_q != ST_IDLE);
  // A bit only counts when running, enabled and not being flushed.
  assign accept_w    = running_w && bus.en && !bus.clear && bus.w_valid;
  assign len_legal_w = (bus.pat_len != '0) && (bus.pat_len <= LEN_W'(PATTERN_W));

  // Shift-in via a cast rather than a slice so PATTERN_W = 1 still elaborates.
  assign hist_shift_w = (hist_q << 1) | PATTERN_W'(bus.w);
  assign fill_inc_w   = (fill_q < len_q) ? (fill_q + LEN_W'(1)) : fill_q;
  // Ones in the low len_q bits; a shift of PATTERN_W yields all ones.
  assign len_mask_w   = ~({PATTERN_W{1'b1}} << len_q);
  assign match_w      = (fill_inc_w == len_q) &&
                        (((hist_shift_w ^ pat_q) & len_mask_w) == '0);

  // State, history, latched configuration and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      hist_q    <= '0;
      fill_q    <= '0;
      pat_q     <= '0;
      len_q     <= '0;
      ovl_q     <= 1'b0;
      z_q       <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      ovl_q     <= ovl_d;
      z_q       <= z_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Next-state, history/fill update, config latch and match pulse.
  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    pat_d     = pat_q;
    len_d     = len_q;
    ovl_d     = ovl_q;
    cfg_err_d = cfg_err_q;
    z_d       = accept_w && match_w;

    if (bus.clear) begin
      // Flush wins over everything else; a running detector restarts filling.
      hist_d = '0;
      fill_d = '0;
      if (running_w) begin
        state_d = ST_FILL;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.en) begin
            if (len_legal_w) begin
              pat_d   = bus.pattern;
              len_d   = bus.pat_len;
              ovl_d   = bus.overlap;
              hist_d  = '0;
              fill_d  = '0;
              state_d = ST_FILL;
            end else begin
              cfg_err_d = 1'b1;
            end
          end
        end
        ST_FILL, ST_DETECT: begin
          if (accept_w) begin
            hist_d = hist_shift_w;
            if (match_w && !ovl_q) begin
              // Non-overlapping: the next match needs pat_len fresh bits.
              fill_d  = '0;
              state_d = ST_FILL;
            end else begin
              fill_d  = fill_inc_w;
              state_d = (fill_inc_w == len_q) ? ST_DETECT : ST_FILL;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Dropping en stops the detector regardless of anything else this cycle.
    if (!bus.en) begin
      state_d = ST_IDLE;
    end
  end

  assign bus.z       = z_q;
  assign bus.busy    = running_w;
  assign bus.cfg_err = cfg_err_q;

`ifdef SEQDET_MATCH_CNT_EN
  logic [MATCH_CNT_W-1:0] cnt_q;

  // Saturating match counter, advanced on the same edge that raises z.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (bus.clear) begin
      cnt_q <= '0;
    end else if (z_d && (cnt_q != {MATCH_CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + MATCH_CNT_W'(1);
    end
  end

  assign bus.match_cnt = cnt_q;
`else
  assign bus.match_cnt = {MATCH_CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param with hand-computed expectations.
// Counter expectations follow whether SEQDET_MATCH_CNT_EN is defined.
module tb_seq_detector_param;

  localparam int PW = 8;
  localparam int LW = 4;
  localparam int CW = 2;
`ifdef SEQDET_MATCH_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_err;

  seq_detector_param_if #(.PATTERN_W(PW), .LEN_W(LW), .MATCH_CNT_W(CW)) bus ();

  seq_detector_param #(.PATTERN_W(PW), .LEN_W(LW), .MATCH_CNT_W(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock with the given bit; sample #1 after the edge.
  task automatic step(input logic valid, input logic bit_v);
    bus.w_valid = valid;
    bus.w       = bit_v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset_n     = 1'b0;
    bus.en      = 1'b0;
    bus.clear   = 1'b0;
    bus.w_valid = 1'b0;
    bus.w       = 1'b0;
    bus.pattern = '0;
    bus.pat_len = '0;
    bus.overlap = 1'b0;
    #12;
    chk("rst_z", 32'(bus.z), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_cfg_err", 32'(bus.cfg_err), 0);
    chk("rst_match_cnt", 32'(bus.match_cnt), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Overlapping 101 over 1,0,1,0,1
    bus.pattern = 8'b101; bus.pat_len = 4'd3; bus.overlap = 1'b1; bus.en = 1'b1;
    step(0, 0);
    chk("ov_busy", 32'(bus.busy), 1);
    step(1, 1); chk("ov_b1", 32'(bus.z), 0);
    step(1, 0); chk("ov_b2", 32'(bus.z), 0);
    step(1, 1); chk("ov_b3", 32'(bus.z), 1);
    step(1, 0); chk("ov_b4", 32'(bus.z), 0);
    step(1, 1); chk("ov_b5", 32'(bus.z), 1);
    bus.en = 1'b0;
    step(1, 1);
    chk("ov_stop_busy", 32'(bus.busy), 0);
    chk("ov_stop_z", 32'(bus.z), 0);

    // Non-overlapping 101 over 1,0,1,0,1
    bus.overlap = 1'b0; bus.en = 1'b1;
    step(0, 0);
    step(1, 1); chk("no_b1", 32'(bus.z), 0);
    step(1, 0); chk("no_b2", 32'(bus.z), 0);
    step(1, 1); chk("no_b3", 32'(bus.z), 1);
    step(1, 0); chk("no_b4", 32'(bus.z), 0);
    step(1, 1); chk("no_b5", 32'(bus.z), 0);
    bus.en = 1'b0;
    step(0, 0);

    // Illegal length 0
    bus.pat_len = 4'd0; bus.en = 1'b1;
    step(0, 0);
    chk("len0_cfg_err", 32'(bus.cfg_err), 1);
    chk("len0_busy", 32'(bus.busy), 0);
    step(1, 1);
    chk("len0_z", 32'(bus.z), 0);
    chk("len0_busy2", 32'(bus.busy), 0);
    bus.en = 1'b0;
    step(0, 0);

    // pat_len=1, pattern=1, gaps; live config changed while busy
    bus.pattern = 8'b1; bus.pat_len = 4'd1; bus.overlap = 1'b0; bus.en = 1'b1;
    step(0, 0);
    bus.pattern = 8'h00; bus.pat_len = 4'd2;
    step(1, 1); chk("l1_b1", 32'(bus.z), 1);
    step(0, 1); chk("l1_gap1", 32'(bus.z), 0);
    step(1, 1); chk("l1_b2", 32'(bus.z), 1);
    step(0, 1); chk("l1_gap2", 32'(bus.z), 0);
    step(1, 0); chk("l1_b3", 32'(bus.z), 0);
    step(1, 1); chk("l1_b4", 32'(bus.z), 1);
    bus.en = 1'b0;
    step(0, 0);

    // Reset after 2 of 3 bits, then restart
    bus.pattern = 8'b101; bus.pat_len = 4'd3; bus.overlap = 1'b1; bus.en = 1'b1;
    step(0, 0);
    step(1, 1);
    step(1, 0);
    bus.w_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_cfg_err", 32'(bus.cfg_err), 0);
    chk("arst_z", 32'(bus.z), 0);
    @(negedge clk);
    reset_n = 1'b1;
    step(0, 0);
    chk("rs_busy", 32'(bus.busy), 1);
    step(1, 1); chk("rs_b1", 32'(bus.z), 0);
    step(1, 0); chk("rs_b2", 32'(bus.z), 0);
    step(1, 1); chk("rs_b3", 32'(bus.z), 1);
    bus.en = 1'b0;
    step(0, 0);

    // Counter, clear and saturation at 2^CW-1
    bus.pattern = 8'b1; bus.pat_len = 4'd1; bus.overlap = 1'b1; bus.en = 1'b1;
    step(0, 0);
    bus.clear = 1'b1;
    step(1, 1);
    chk("clr_z", 32'(bus.z), 0);
    chk("clr_cnt", 32'(bus.match_cnt), 0);
    chk("clr_busy", 32'(bus.busy), 1);
    bus.clear = 1'b0;
    step(1, 1); chk("cnt_z1", 32'(bus.z), 1);
    step(1, 1);
    chk("cnt_2", 32'(bus.match_cnt), CNT_EN ? 32'd2 : 32'd0);
    step(1, 1);
    step(1, 1);
    step(1, 1); chk("cnt_z5", 32'(bus.z), 1);
    chk("cnt_sat", 32'(bus.match_cnt), CNT_EN ? 32'd3 : 32'd0);
    bus.clear = 1'b1;
    step(0, 0);
    chk("cnt_clear", 32'(bus.match_cnt), 0);
    bus.clear = 1'b0;
    bus.en = 1'b0;
    step(0, 0);

    // Illegal length above PATTERN_W
    bus.pat_len = 4'd9; bus.en = 1'b1;
    step(0, 0);
    chk("len9_cfg_err", 32'(bus.cfg_err), 1);
    chk("len9_busy", 32'(bus.busy), 0);
    bus.en = 1'b0;
    step(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
